grayscale_pipe: RTL and testbench
=================================

Name: grayscale_pipe

Overview:
Pipelined colour-to-grayscale converter feeding the colour-scramble stage ahead of the VGA output. Takes 4-bit RGB pixels from the frame-buffer read path with their timing signals (DE, HSYNC, VSYNC). Produces RGB for the scramble stage as passthrough, luma, average or max-channel gray. Timing signals are delayed to match the pixel latency. The mode is captured once per frame so a mid-frame switch change never tears the image.

Parameters:
COLOR_W, 4, bits per colour channel (all arithmetic scales with it)
VSYNC_ACTIVE, 1'b0, active level of vsync_in/vsync_out (0 = active-low)
HSYNC_ACTIVE, 1'b0, active level of hsync_in/hsync_out

Ports:
clk  in  1  pixel clock
rst  in  1  reset, synchronous, active-high
mode_sw  in  2  gray mode switches: 0 passthrough, 1 luma, 2 average, 3 max
R_in  in  COLOR_W  red from frame-buffer read path
G_in  in  COLOR_W  green
B_in  in  COLOR_W  blue
de_in  in  1  display enable; pixel valid when 1
hsync_in  in  1  horizontal sync
vsync_in  in  1  vertical sync
R_out  out  COLOR_W  red to colour-scramble stage
G_out  out  COLOR_W  green to colour-scramble stage
B_out  out  COLOR_W  blue to colour-scramble stage
de_out  out  1  de_in delayed 3 cycles
hsync_out  out  1  hsync_in delayed 3 cycles
vsync_out  out  1  vsync_in delayed 3 cycles

Behaviour:
- Single clock domain. Reset is synchronous and active-high on `rst`, sampled on rising `clk`.
- Reset values:
  - R/G/B_out = 0, de_out = 0.
  - hsync_out = ~HSYNC_ACTIVE, vsync_out = ~VSYNC_ACTIVE.
  - mode_q = 0 and every pipeline stage cleared, including the mode tags and the sync/DE shift registers (cleared to their inactive levels).
- Mode capture:
  - vsync_prev is a register of vsync_in.
  - On the cycle where vsync_in == VSYNC_ACTIVE and vsync_prev != VSYNC_ACTIVE (active edge), mode_q <= mode_sw.
  - mode_q is otherwise held. mode_sw changes at any other time have no effect until the next active edge.
  - The edge detector reset value is vsync_prev = ~VSYNC_ACTIVE, so a sync already active at reset release counts as an edge.
- Pipeline: fixed latency of 3 cycles, no stalls, one pixel per clock. Each stage carries RGB, de, hsync, vsync and a 2-bit mode tag.
  - S1 (registers inputs, tag = mode_q):
    - pR = 77*R, pG = 150*G, pB = 29*B
    - sum = R+G+B
    - mx1 = max(R,G)
    - Raw RGB is carried forward.
  - S2:
    - luma_acc = pR+pG+pB+128
    - avg_acc = 85*sum+128
    - mx = max(mx1,B)
  - S3 (output register):
    - luma = luma_acc[COLOR_W+7:8], avg = avg_acc[COLOR_W+7:8].
    - Select by tag: tag 0 gives raw RGB; tags 1/2/3 drive R=G=B = luma / avg / mx respectively.
    - If the stage's de == 0, RGB_out = 0 regardless of mode.
- Width rules:
  - Products are COLOR_W+8 bits; sum is COLOR_W+2 bits.
  - Weights sum to 256, so equal channels map to themselves: R=G=B=v gives luma = avg = max = v.
  - No overflow is possible: the maximum accumulator for COLOR_W=4 is 3968.
- Boundary conditions:
  - A mode edge mid-pipeline changes only pixels entering S1 after mode_q updates; in-flight pixels keep their tag.
  - Reset mid-frame flushes the pipeline. Outputs sit at reset values for 3 cycles after rst deasserts, then track inputs.
  - Sync/DE delay is independent of de (blanking intervals still shift through).

Test Plan:
- Reset, then drive de_in=1, RGB=(15,0,0) with mode 1 captured at a vsync edge -> after 3 cycles RGB_out=(5,5,5). Repeat with (0,15,0) -> (9,9,9) and (0,0,15) -> (2,2,2).
- Mode 2 with RGB=(12,4,2) -> (6,6,6). Mode 3 with the same input -> (12,12,12). Mode 0 -> (12,4,2). Gray sweep R=G=B=0..15 in modes 1/2/3 -> output equals input each cycle.
- Latency/alignment: toggle hsync_in, vsync_in and de_in with distinct patterns -> outputs are exact 3-cycle-delayed copies; RGB_out=0 whenever de_out=0, even with nonzero RGB_in.
- Mode gating: change mode_sw 1->3 mid-frame -> output stays luma. At the next vsync active edge, pixels entering after that edge produce max; pixels already in flight keep luma.
- Reset mid-stream: assert rst for 1 cycle during active video in mode 2 -> next cycle R/G/B_out=0, de_out=0, syncs inactive. mode_q=0, so pixels after release are passthrough until the next vsync edge.
- Parameter check at VSYNC_ACTIVE=1 -> mode captured on the vsync_in rising edge, and vsync_out resets to 0.

Source files
------------

// File: rtl/grayscale_pipe.sv
// Three-stage colour-to-grayscale pipeline (passthrough / luma / average / max)
// with DE and sync delayed to match; the mode is latched on the vsync active edge.
module grayscale_pipe #(
  parameter int   COLOR_W      = 4,
  parameter logic VSYNC_ACTIVE = 1'b0,
  parameter logic HSYNC_ACTIVE = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode_sw,
  input  logic [COLOR_W-1:0] R_in,
  input  logic [COLOR_W-1:0] G_in,
  input  logic [COLOR_W-1:0] B_in,
  input  logic               de_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  output logic [COLOR_W-1:0] R_out,
  output logic [COLOR_W-1:0] G_out,
  output logic [COLOR_W-1:0] B_out,
  output logic               de_out,
  output logic               hsync_out,
  output logic               vsync_out
);
  localparam int PW = COLOR_W + 8;
  localparam int SW = COLOR_W + 2;

  logic               vsync_prev_q, vsync_prev_d;
  logic [1:0]         mode_q, mode_d;

  logic [COLOR_W-1:0] s1_r_q, s1_g_q, s1_b_q, s1_mx_q;
  logic [COLOR_W-1:0] s1_r_d, s1_g_d, s1_b_d, s1_mx_d;
  logic [PW-1:0]      s1_pr_q, s1_pg_q, s1_pb_q, s1_pr_d, s1_pg_d, s1_pb_d;
  logic [SW-1:0]      s1_sum_q, s1_sum_d;
  logic               s1_de_q, s1_hs_q, s1_vs_q, s1_de_d, s1_hs_d, s1_vs_d;
  logic [1:0]         s1_tag_q, s1_tag_d;

  logic [COLOR_W-1:0] s2_r_q, s2_g_q, s2_b_q, s2_mx_q;
  logic [COLOR_W-1:0] s2_r_d, s2_g_d, s2_b_d, s2_mx_d;
  logic [PW-1:0]      s2_luma_q, s2_avg_q, s2_luma_d, s2_avg_d;
  logic               s2_de_q, s2_hs_q, s2_vs_q, s2_de_d, s2_hs_d, s2_vs_d;
  logic [1:0]         s2_tag_q, s2_tag_d;

  logic [COLOR_W-1:0] out_r_q, out_g_q, out_b_q, out_r_d, out_g_d, out_b_d;
  logic               out_de_q, out_hs_q, out_vs_q, out_de_d, out_hs_d, out_vs_d;
  logic [COLOR_W-1:0] luma, avg;

  // Rounding fraction of the accumulators is dropped by design.
  logic unused_frac;
  assign unused_frac = ^{s2_luma_q[7:0], s2_avg_q[7:0]};

  always_comb begin
    vsync_prev_d = vsync_in;
    mode_d       = mode_q;
    if (vsync_in == VSYNC_ACTIVE && vsync_prev_q != VSYNC_ACTIVE)
      mode_d = mode_sw;

    s1_r_d   = R_in;
    s1_g_d   = G_in;
    s1_b_d   = B_in;
    s1_pr_d  = PW'(R_in) * PW'(77);
    s1_pg_d  = PW'(G_in) * PW'(150);
    s1_pb_d  = PW'(B_in) * PW'(29);
    s1_sum_d = SW'(R_in) + SW'(G_in) + SW'(B_in);
    s1_mx_d  = (R_in > G_in) ? R_in : G_in;
    s1_de_d  = de_in;
    s1_hs_d  = hsync_in;
    s1_vs_d  = vsync_in;
    s1_tag_d = mode_q;

    s2_r_d    = s1_r_q;
    s2_g_d    = s1_g_q;
    s2_b_d    = s1_b_q;
    s2_luma_d = s1_pr_q + s1_pg_q + s1_pb_q + PW'(128);
    s2_avg_d  = PW'(s1_sum_q) * PW'(85) + PW'(128);
    s2_mx_d   = (s1_mx_q > s1_b_q) ? s1_mx_q : s1_b_q;
    s2_de_d   = s1_de_q;
    s2_hs_d   = s1_hs_q;
    s2_vs_d   = s1_vs_q;
    s2_tag_d  = s1_tag_q;

    luma     = s2_luma_q[COLOR_W+7:8];
    avg      = s2_avg_q[COLOR_W+7:8];
    out_r_d  = '0;
    out_g_d  = '0;
    out_b_d  = '0;
    out_de_d = s2_de_q;
    out_hs_d = s2_hs_q;
    out_vs_d = s2_vs_q;
    // Blanking pixels are forced black whatever the mode.
    if (s2_de_q) begin
      unique case (s2_tag_q)
        2'd0: begin out_r_d = s2_r_q; out_g_d = s2_g_q; out_b_d = s2_b_q; end
        2'd1: begin out_r_d = luma;   out_g_d = luma;   out_b_d = luma;   end
        2'd2: begin out_r_d = avg;    out_g_d = avg;    out_b_d = avg;    end
        default: begin out_r_d = s2_mx_q; out_g_d = s2_mx_q; out_b_d = s2_mx_q; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_prev_q <= ~VSYNC_ACTIVE;
      mode_q       <= 2'd0;
      s1_r_q <= '0; s1_g_q <= '0; s1_b_q <= '0; s1_mx_q <= '0;
      s1_pr_q <= '0; s1_pg_q <= '0; s1_pb_q <= '0; s1_sum_q <= '0;
      s1_de_q <= 1'b0; s1_hs_q <= ~HSYNC_ACTIVE; s1_vs_q <= ~VSYNC_ACTIVE; s1_tag_q <= 2'd0;
      s2_r_q <= '0; s2_g_q <= '0; s2_b_q <= '0; s2_mx_q <= '0;
      s2_luma_q <= '0; s2_avg_q <= '0;
      s2_de_q <= 1'b0; s2_hs_q <= ~HSYNC_ACTIVE; s2_vs_q <= ~VSYNC_ACTIVE; s2_tag_q <= 2'd0;
      out_r_q <= '0; out_g_q <= '0; out_b_q <= '0;
      out_de_q <= 1'b0; out_hs_q <= ~HSYNC_ACTIVE; out_vs_q <= ~VSYNC_ACTIVE;
    end else begin
      vsync_prev_q <= vsync_prev_d;
      mode_q       <= mode_d;
      s1_r_q <= s1_r_d; s1_g_q <= s1_g_d; s1_b_q <= s1_b_d; s1_mx_q <= s1_mx_d;
      s1_pr_q <= s1_pr_d; s1_pg_q <= s1_pg_d; s1_pb_q <= s1_pb_d; s1_sum_q <= s1_sum_d;
      s1_de_q <= s1_de_d; s1_hs_q <= s1_hs_d; s1_vs_q <= s1_vs_d; s1_tag_q <= s1_tag_d;
      s2_r_q <= s2_r_d; s2_g_q <= s2_g_d; s2_b_q <= s2_b_d; s2_mx_q <= s2_mx_d;
      s2_luma_q <= s2_luma_d; s2_avg_q <= s2_avg_d;
      s2_de_q <= s2_de_d; s2_hs_q <= s2_hs_d; s2_vs_q <= s2_vs_d; s2_tag_q <= s2_tag_d;
      out_r_q <= out_r_d; out_g_q <= out_g_d; out_b_q <= out_b_d;
      out_de_q <= out_de_d; out_hs_q <= out_hs_d; out_vs_q <= out_vs_d;
    end
  end

  assign R_out     = out_r_q;
  assign G_out     = out_g_q;
  assign B_out     = out_b_q;
  assign de_out    = out_de_q;
  assign hsync_out = out_hs_q;
  assign vsync_out = out_vs_q;
endmodule

// File: tb/tb_grayscale_pipe.sv
// Bench for grayscale_pipe: directed vector table, hand-written corner sequences,
// and random traffic checked every cycle against a per-pixel arithmetic model.
module tb_grayscale_pipe;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode_sw;
  logic [3:0] R_in, G_in, B_in;
  logic       de_in, hsync_in, vsync_in, vsync1_in;
  logic [3:0] R_out, G_out, B_out, R1, G1, B1;
  logic       de_out, hsync_out, vsync_out, de1, hs1, vs1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  assign vsync1_in = ~vsync_in;

  grayscale_pipe #(.COLOR_W(4), .VSYNC_ACTIVE(1'b0), .HSYNC_ACTIVE(1'b0)) dut (
    .clk(clk), .rst(rst), .mode_sw(mode_sw), .R_in(R_in), .G_in(G_in), .B_in(B_in),
    .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .R_out(R_out), .G_out(G_out), .B_out(B_out),
    .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out));

  // Same stream with vsync inverted into an active-high instance.
  grayscale_pipe #(.COLOR_W(4), .VSYNC_ACTIVE(1'b1), .HSYNC_ACTIVE(1'b0)) dut1 (
    .clk(clk), .rst(rst), .mode_sw(mode_sw), .R_in(R_in), .G_in(G_in), .B_in(B_in),
    .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync1_in),
    .R_out(R1), .G_out(G1), .B_out(B1),
    .de_out(de1), .hsync_out(hs1), .vsync_out(vs1));

  typedef struct {
    logic [3:0] r, g, b;
    logic       de, hs, vs;
    logic [1:0] tag;
  } ent_t;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] r, g, b, er, eg, eb;
  } vec_t;

  ent_t       hist[$];
  logic [1:0] mode_m;
  logic       vprev_m;

  function automatic logic [11:0] expect_rgb(ent_t e);
    int r = e.r, g = e.g, b = e.b, y = 0;
    logic [3:0] yv;
    if (!e.de) return 12'd0;
    case (e.tag)
      2'd0: return {e.r, e.g, e.b};
      2'd1: y = (77 * r + 150 * g + 29 * b + 128) / 256;
      2'd2: y = ((r + g + b) * 85 + 128) / 256;
      default: begin
        y = r;
        if (g > y) y = g;
        if (b > y) y = b;
      end
    endcase
    yv = 4'(y);
    return {yv, yv, yv};
  endfunction

  task automatic model_edge();
    ent_t e;
    if (rst) begin
      hist.delete();
      e = '{r: 4'd0, g: 4'd0, b: 4'd0, de: 1'b0, hs: 1'b1, vs: 1'b1, tag: 2'd0};
      repeat (3) hist.push_back(e);
      mode_m  = 2'd0;
      vprev_m = 1'b1;
    end else begin
      e = '{r: R_in, g: G_in, b: B_in, de: de_in, hs: hsync_in, vs: vsync_in, tag: mode_m};
      hist.push_back(e);
      if (hist.size() > 3) void'(hist.pop_front());
      if (vsync_in == 1'b0 && vprev_m != 1'b0) mode_m = mode_sw;
      vprev_m = vsync_in;
    end
  endtask

  task automatic model_check();
    logic [14:0] exp0, act0, exp1, act1;
    if (hist.size() != 3) return;
    exp0 = {expect_rgb(hist[0]), hist[0].de, hist[0].hs, hist[0].vs};
    exp1 = {expect_rgb(hist[0]), hist[0].de, hist[0].hs, ~hist[0].vs};
    act0 = {R_out, G_out, B_out, de_out, hsync_out, vsync_out};
    act1 = {R1, G1, B1, de1, hs1, vs1};
    tests++;
    if (act0 !== exp0) begin
      fails++;
      $display("FAIL model_vs_low t=%0t act rgb/de/hs/vs=%h required=%h", $time, act0, exp0);
    end
    tests++;
    if (act1 !== exp1) begin
      fails++;
      $display("FAIL model_vs_high t=%0t act rgb/de/hs/vs=%h required=%h", $time, act1, exp1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic chk(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s act=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic set_pix(logic [3:0] r, logic [3:0] g, logic [3:0] b, logic de);
    R_in = r; G_in = g; B_in = b; de_in = de;
  endtask

  task automatic capture_mode(logic [1:0] m);
    mode_sw = m;
    set_pix(4'd0, 4'd0, 4'd0, 1'b0);
    vsync_in = 1'b0;
    step();
    vsync_in = 1'b1;
    step();
  endtask

  vec_t vecs[6];
  int   outs[4];

  initial begin
    vecs[0] = '{mode: 2'd1, r: 4'd15, g: 4'd0,  b: 4'd0,  er: 4'd5,  eg: 4'd5,  eb: 4'd5};
    vecs[1] = '{mode: 2'd1, r: 4'd0,  g: 4'd15, b: 4'd0,  er: 4'd9,  eg: 4'd9,  eb: 4'd9};
    vecs[2] = '{mode: 2'd1, r: 4'd0,  g: 4'd0,  b: 4'd15, er: 4'd2,  eg: 4'd2,  eb: 4'd2};
    vecs[3] = '{mode: 2'd2, r: 4'd12, g: 4'd4,  b: 4'd2,  er: 4'd6,  eg: 4'd6,  eb: 4'd6};
    vecs[4] = '{mode: 2'd3, r: 4'd12, g: 4'd4,  b: 4'd2,  er: 4'd12, eg: 4'd12, eb: 4'd12};
    vecs[5] = '{mode: 2'd0, r: 4'd12, g: 4'd4,  b: 4'd2,  er: 4'd12, eg: 4'd4,  eb: 4'd2};

    rst = 1'b1; mode_sw = 2'd0; hsync_in = 1'b1; vsync_in = 1'b1;
    set_pix(4'd7, 4'd7, 4'd7, 1'b1);
    step();
    step();
    chk("reset_rgb_de", {R_out, G_out, B_out, de_out}, 0);
    chk("reset_syncs", {hsync_out, vsync_out}, 3);
    chk("reset_vsync_out_active_high", vs1, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      capture_mode(vecs[i].mode);
      set_pix(vecs[i].r, vecs[i].g, vecs[i].b, 1'b1);
      repeat (3) step();
      chk($sformatf("vec%0d_rgb", i), {R_out, G_out, B_out}, {vecs[i].er, vecs[i].eg, vecs[i].eb});
      chk($sformatf("vec%0d_rgb_vshigh", i), {R1, G1, B1}, {vecs[i].er, vecs[i].eg, vecs[i].eb});
    end

    for (int m = 1; m < 4; m++) begin
      capture_mode(2'(m));
      for (int v = 0; v < 18; v++) begin
        set_pix(4'(v > 15 ? 15 : v), 4'(v > 15 ? 15 : v), 4'(v > 15 ? 15 : v), 1'b1);
        step();
        if (v >= 2) chk($sformatf("gray_m%0d_v%0d", m, v - 2), {R_out, G_out, B_out}, {3{4'(v - 2)}});
      end
    end

    // Blanking with nonzero colour must produce black.
    set_pix(4'd9, 4'd3, 4'd14, 1'b0);
    repeat (3) step();
    chk("blank_black", {R_out, G_out, B_out, de_out}, 0);

    // Mid-frame switch change stays gated until the next vsync edge.
    capture_mode(2'd1);
    set_pix(4'd15, 4'd0, 4'd0, 1'b1);
    mode_sw = 2'd3;
    repeat (4) step();
    chk("gated_still_luma", R_out, 5);
    vsync_in = 1'b0;
    step();
    outs[0] = R_out;
    vsync_in = 1'b1;
    for (int k = 1; k < 4; k++) begin
      step();
      outs[k] = R_out;
    end
    chk("edge_inflight0", outs[0], 5);
    chk("edge_inflight1", outs[1], 5);
    chk("edge_inflight2", outs[2], 5);
    chk("edge_new_max", outs[3], 15);

    // Reset during active video in average mode.
    capture_mode(2'd2);
    set_pix(4'd12, 4'd4, 4'd2, 1'b1);
    hsync_in = 1'b0;
    repeat (3) step();
    chk("pre_reset_avg", R_out, 6);
    rst = 1'b1;
    step();
    chk("midrst_rgb_de", {R_out, G_out, B_out, de_out}, 0);
    chk("midrst_syncs", {hsync_out, vsync_out}, 3);
    rst = 1'b0;
    step();
    step();
    chk("post_rst_hold", {R_out, de_out}, 0);
    step();
    chk("post_rst_passthrough", {R_out, G_out, B_out}, {4'd12, 4'd4, 4'd2});
    hsync_in = 1'b1;

    for (int n = 0; n < 800; n++) begin
      rst      = ($urandom_range(0, 99) == 0);
      mode_sw  = 2'($urandom_range(0, 3));
      set_pix(4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 3) != 0);
      hsync_in = ($urandom_range(0, 7) != 0);
      vsync_in = ($urandom_range(0, 19) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
